// File: rtl/hazard_pkg.sv
// Shared types, default parameters and helpers for the pipeline hazard controller.
package hazard_pkg;

  // Stall sequencer states.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LSTALL = 1'b1
  } state_e;

  localparam int unsigned REG_AW_DEF         = 5;
  localparam int unsigned LOAD_STALL_DEF     = 1;
  localparam int unsigned MDU_LAT_DEF        = 4;
  localparam int unsigned BR_FLUSH_DEPTH_DEF = 1;

  // Counter width able to hold values 0..n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Legal parameter ranges.
  function automatic bit params_ok(input int unsigned reg_aw, input int unsigned load_stall,
                                   input int unsigned mdu_lat, input int unsigned br_depth);
    return (reg_aw >= 1) && (load_stall >= 1) && (load_stall <= 3) &&
           (mdu_lat >= 1) && (mdu_lat <= 15) && (br_depth >= 1) && (br_depth <= 3);
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// ID-stage hazard signals: pipeline side (master) and hazard unit side (slave).
interface hazard_ctrl_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) ();

  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_uses_rs_i;
  logic              id_uses_rt_i;
  logic              id_is_mdu_i;
  logic              id_rd_hilo_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rt_i;
  logic              pc_src_i;

  logic              pc_write_o;
  logic              ifid_write_o;
  logic              if_flush_o;
  logic              id_flush_o;
  logic              ex_flush_o;
  logic              busy_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, id_is_mdu_i, id_rd_hilo_i,
           ex_memread_i, ex_rt_i, pc_src_i,
    input  pc_write_o, ifid_write_o, if_flush_o, id_flush_o, ex_flush_o, busy_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i, id_is_mdu_i, id_rd_hilo_i,
           ex_memread_i, ex_rt_i, pc_src_i,
    output pc_write_o, ifid_write_o, if_flush_o, id_flush_o, ex_flush_o, busy_o
  );

endinterface

// File: rtl/hazard_cnt.sv
// Loadable down-counter that saturates at zero; load has priority over decrement.
module hazard_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / MDU stall and branch flush control for the 5-stage pipeline.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW         = REG_AW_DEF,
  parameter int unsigned LOAD_STALL     = LOAD_STALL_DEF,
  parameter int unsigned MDU_LAT        = MDU_LAT_DEF,
  parameter int unsigned BR_FLUSH_DEPTH = BR_FLUSH_DEPTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_ctrl_unit_if.slave  hz
);

  localparam int unsigned LCNT_W = cnt_w(LOAD_STALL);
  localparam int unsigned MCNT_W = cnt_w(MDU_LAT);

  localparam logic [REG_AW-1:0] REG_ZERO  = '0;
  localparam logic [LCNT_W-1:0] LCNT_INIT = LCNT_W'(LOAD_STALL - 1);
  localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);
  localparam logic [MCNT_W-1:0] MCNT_INIT = MCNT_W'(MDU_LAT);

  if (!params_ok(REG_AW, LOAD_STALL, MDU_LAT, BR_FLUSH_DEPTH)) begin : g_param_err
    $error("hazard_ctrl_unit: parameter out of range");
  end

  state_e             state;
  state_e             state_nxt;
  logic [LCNT_W-1:0]  lcnt;
  logic               lcnt_zero;
  logic               lcnt_load;
  logic [LCNT_W-1:0]  lcnt_val;
  logic               lcnt_dec;
  logic [MCNT_W-1:0]  mdu_cnt;
  logic               mdu_zero;
  logic               mdu_load;
  logic               load_hit;
  logic               mdu_hit;
  logic               stall;

  // Hazard detection; register 0 never creates a dependency.
  always_comb begin
    load_hit = hz.ex_memread_i && (hz.ex_rt_i != REG_ZERO) &&
               ((hz.id_uses_rs_i && (hz.id_rs_i == hz.ex_rt_i)) ||
                (hz.id_uses_rt_i && (hz.id_rt_i == hz.ex_rt_i)));
    mdu_hit  = !mdu_zero && (hz.id_is_mdu_i || hz.id_rd_hilo_i);
    stall    = (state == LSTALL) || load_hit || mdu_hit;
    mdu_load = hz.id_is_mdu_i && mdu_zero && !stall && !hz.pc_src_i;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and bubble counter control; a taken branch cancels any pending bubbles.
  always_comb begin
    state_nxt = state;
    lcnt_load = 1'b0;
    lcnt_val  = LCNT_INIT;
    lcnt_dec  = 1'b0;
    if (hz.pc_src_i) begin
      state_nxt = IDLE;
      lcnt_load = 1'b1;
      lcnt_val  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_hit && (LOAD_STALL > 1)) begin
            state_nxt = LSTALL;
            lcnt_load = 1'b1;
          end
        end
        LSTALL: begin
          lcnt_dec = 1'b1;
          if ((lcnt == LCNT_ONE) || lcnt_zero) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: reset, then branch, then stall, else free-running pipeline.
  always_comb begin
    hz.pc_write_o   = 1'b1;
    hz.ifid_write_o = 1'b1;
    hz.if_flush_o   = 1'b0;
    hz.id_flush_o   = 1'b0;
    hz.ex_flush_o   = 1'b0;
    hz.busy_o       = (state != IDLE) || !mdu_zero;
    if (rst_i) begin
      hz.pc_write_o   = 1'b0;
      hz.ifid_write_o = 1'b0;
      hz.if_flush_o   = 1'b1;
      hz.id_flush_o   = 1'b1;
      hz.ex_flush_o   = 1'b1;
      hz.busy_o       = 1'b0;
    end else if (hz.pc_src_i) begin
      hz.if_flush_o = 1'b1;
      hz.id_flush_o = (BR_FLUSH_DEPTH >= 2);
      hz.ex_flush_o = (BR_FLUSH_DEPTH == 3);
    end else if (stall) begin
      hz.pc_write_o   = 1'b0;
      hz.ifid_write_o = 1'b0;
      hz.id_flush_o   = 1'b1;
    end
  end

  // Remaining forced load bubbles.
  hazard_cnt #(.W(LCNT_W)) u_lcnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (lcnt_load),
    .value (lcnt_val),
    .dec   (lcnt_dec),
    .cnt   (lcnt),
    .zero  (lcnt_zero)
  );

  // Multiply/divide busy cycles; decrements every cycle regardless of stalls or branches.
  hazard_cnt #(.W(MCNT_W)) u_mdu_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .load  (mdu_load),
    .value (MCNT_INIT),
    .dec   (1'b1),
    .cnt   (mdu_cnt),
    .zero  (mdu_zero)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Two configurations driven with identical stimulus and checked against a cycle-indexed model.
module tb_hazard_ctrl_unit;

  localparam int LS [2] = '{3, 1};
  localparam int ML [2] = '{4, 4};
  localparam int BD [2] = '{2, 3};

  logic clk;
  logic r_rst;
  logic [4:0] r_rs, r_rt, r_ert;
  logic r_urs, r_urt, r_mdu, r_hilo, r_mr, r_pcs;

  int total;
  int bad;
  longint cyc;
  longint stall_until [2];
  longint mdu_until [2];
  int st_cnt0, st_cnt1;

  hazard_ctrl_unit_if #(.REG_AW(5)) hz0 ();
  hazard_ctrl_unit_if #(.REG_AW(5)) hz1 ();

  assign hz0.id_rs_i = r_rs;   assign hz1.id_rs_i = r_rs;
  assign hz0.id_rt_i = r_rt;   assign hz1.id_rt_i = r_rt;
  assign hz0.id_uses_rs_i = r_urs;  assign hz1.id_uses_rs_i = r_urs;
  assign hz0.id_uses_rt_i = r_urt;  assign hz1.id_uses_rt_i = r_urt;
  assign hz0.id_is_mdu_i = r_mdu;   assign hz1.id_is_mdu_i = r_mdu;
  assign hz0.id_rd_hilo_i = r_hilo; assign hz1.id_rd_hilo_i = r_hilo;
  assign hz0.ex_memread_i = r_mr;   assign hz1.ex_memread_i = r_mr;
  assign hz0.ex_rt_i = r_ert;  assign hz1.ex_rt_i = r_ert;
  assign hz0.pc_src_i = r_pcs; assign hz1.pc_src_i = r_pcs;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(3), .MDU_LAT(4), .BR_FLUSH_DEPTH(2)) u_dut0 (
    .clk_i (clk),
    .rst_i (r_rst),
    .hz    (hz0.slave)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_STALL(1), .MDU_LAT(4), .BR_FLUSH_DEPTH(3)) u_dut1 (
    .clk_i (clk),
    .rst_i (r_rst),
    .hz    (hz1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Model: a load-use hit at cycle N forces stalls through N+LS-1; an MDU op at N blocks N+1..N+ML.
  task automatic model_check(input int k, input logic [5:0] got);
    bit e_pc, e_ifid, e_if, e_id, e_ex, e_busy;
    bit forced, mbusy, lhit, mhit, stall;
    e_pc = 1; e_ifid = 1; e_if = 0; e_id = 0; e_ex = 0; e_busy = 0; stall = 0;
    if (r_rst) begin
      e_pc = 0; e_ifid = 0; e_if = 1; e_id = 1; e_ex = 1; e_busy = 0;
      stall_until[k] = -1;
      mdu_until[k]   = -1;
    end else begin
      forced = (cyc <= stall_until[k]);
      mbusy  = (cyc <= mdu_until[k]);
      lhit   = r_mr && (r_ert != 0) && ((r_urs && r_rs == r_ert) || (r_urt && r_rt == r_ert));
      mhit   = mbusy && (r_mdu || r_hilo);
      e_busy = forced || mbusy;
      if (r_pcs) begin
        e_if = 1; e_id = (BD[k] >= 2); e_ex = (BD[k] == 3);
        stall_until[k] = -1;
      end else begin
        stall = forced || lhit || mhit;
        if (stall) begin e_pc = 0; e_ifid = 0; e_id = 1; end
        if (lhit && !forced) stall_until[k] = cyc + LS[k] - 1;
      end
      if (!r_pcs && r_mdu && !mbusy && !stall) mdu_until[k] = cyc + ML[k];
    end
    chk($sformatf("i%0d pc_write", k),   32'(got[5]), 32'(e_pc));
    chk($sformatf("i%0d ifid_write", k), 32'(got[4]), 32'(e_ifid));
    chk($sformatf("i%0d if_flush", k),   32'(got[3]), 32'(e_if));
    chk($sformatf("i%0d id_flush", k),   32'(got[2]), 32'(e_id));
    chk($sformatf("i%0d ex_flush", k),   32'(got[1]), 32'(e_ex));
    chk($sformatf("i%0d busy", k),       32'(got[0]), 32'(e_busy));
  endtask

  task automatic apply(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic mdu, input logic hilo,
                       input logic mr, input logic [4:0] ert, input logic pcs);
    r_rst = rst; r_rs = rs; r_rt = rt; r_urs = urs; r_urt = urt;
    r_mdu = mdu; r_hilo = hilo; r_mr = mr; r_ert = ert; r_pcs = pcs;
    @(negedge clk);
    model_check(0, {hz0.pc_write_o, hz0.ifid_write_o, hz0.if_flush_o,
                    hz0.id_flush_o, hz0.ex_flush_o, hz0.busy_o});
    model_check(1, {hz1.pc_write_o, hz1.ifid_write_o, hz1.if_flush_o,
                    hz1.id_flush_o, hz1.ex_flush_o, hz1.busy_o});
    if (!hz0.pc_write_o) st_cnt0++;
    if (!hz1.pc_write_o) st_cnt1++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load_hit();
    apply(0, 8, 0, 1, 0, 0, 0, 1, 8, 0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    st_cnt0 = 0; st_cnt1 = 0;
    for (int k = 0; k < 2; k++) begin stall_until[k] = -1; mdu_until[k] = -1; end

    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // Load-use held one cycle: LOAD_STALL bubbles in total.
    st_cnt0 = 0; st_cnt1 = 0;
    load_hit();
    repeat (4) idle();
    chk("ls_bubbles_3", 32'(st_cnt0), 32'd3);
    chk("ls_bubbles_1", 32'(st_cnt1), 32'd1);

    // Register 0 never hazards.
    st_cnt0 = 0; st_cnt1 = 0;
    apply(0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
    chk("r0_no_stall", 32'(st_cnt0 + st_cnt1), 32'd0);

    // mult then mfhi: blocked for MDU_LAT cycles, passes after.
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    st_cnt0 = 0; st_cnt1 = 0;
    repeat (4) apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("mdu_block0", 32'(st_cnt0), 32'd4);
    chk("mdu_block1", 32'(st_cnt1), 32'd4);
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("mdu_pass", 32'(st_cnt0), 32'd4);

    // Branch during the 2nd bubble exits the stall.
    load_hit();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    st_cnt0 = 0;
    idle();
    chk("br_exit_nostall", 32'(st_cnt0), 32'd0);
    idle();

    // Reset mid-stall and mid-MDU.
    apply(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    load_hit();
    apply(1, 8, 0, 1, 0, 0, 1, 1, 8, 0);
    st_cnt0 = 0; st_cnt1 = 0;
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("rst_no_residual", 32'(st_cnt0 + st_cnt1), 32'd0);

    // Randomized traffic biased toward collisions.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 99) < 2),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage MIPS CPU; sits beside the ID stage and drives PC/IF-ID write enables and per-stage flushes. It generalises load-use detection to a configurable register-address width and a configurable number of load bubbles. It adds a multi-cycle multiply/divide busy tracker and a configurable-depth branch flush. Stall sequencing is held in an FSM with a down-counter, so multi-cycle stalls need no upstream re-detection.

## Interface
- REG_AW, 5, register-address width
- LOAD_STALL, 1, bubble cycles inserted on load-use (1..3)
- MDU_LAT, 4, busy cycles after a mult/div issues (1..15)
- BR_FLUSH_DEPTH, 1, stages flushed on a taken branch (1=IF, 2=IF+ID, 3=IF+ID+EX)
- clk_i  in  1  clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- id_rs_i, id_rt_i  in  REG_AW  source registers of the instruction in ID
- id_uses_rs_i, id_uses_rt_i  in  1  ID instruction actually reads rs / rt
- id_is_mdu_i  in  1  ID instruction is mult/div
- id_rd_hilo_i  in  1  ID instruction is mfhi/mflo
- ex_memread_i  in  1  instruction in EX is a load
- ex_rt_i  in  REG_AW  load destination register in EX
- pc_src_i  in  1  taken branch/jump resolved this cycle
- pc_write_o  out  1  PC update enable (1 = write)
- ifid_write_o  out  1  IF/ID register enable (1 = write)
- if_flush_o, id_flush_o, ex_flush_o  out  1  zero the IF/ID, ID/EX, EX/MEM payload
- busy_o  out  1  FSM not in IDLE or MDU counter non-zero

## Operation
- Load-use hit: ex_memread_i && ex_rt_i != 0 && ((id_uses_rs_i && id_rs_i == ex_rt_i) || (id_uses_rt_i && id_rt_i == ex_rt_i)). Register 0 never hazards.
- MDU hit: mdu_cnt != 0 && (id_is_mdu_i || id_rd_hilo_i).
- Stall response: pc_write_o=0, ifid_write_o=0, id_flush_o=1 (bubble into ID/EX).
- FSM states: IDLE and LSTALL.
  - IDLE: on a load-use hit, stall this cycle combinationally. If LOAD_STALL>1, go to LSTALL with lcnt=LOAD_STALL-1.
  - LSTALL: stall unconditionally and decrement lcnt. At lcnt==1, return to IDLE next cycle.
- MDU counter: when id_is_mdu_i, mdu_cnt==0, no stall and no pc_src_i, load mdu_cnt=MDU_LAT. It decrements every cycle to 0 and saturates there. It runs independently of the FSM and of branches.
- Branch, highest priority:
  - pc_src_i forces if_flush_o=1, id_flush_o=(BR_FLUSH_DEPTH>=2), ex_flush_o=(BR_FLUSH_DEPTH==3).
  - pc_write_o=1 so the target loads; ifid_write_o=1.
  - Any load stall is suppressed, and the FSM goes to IDLE with lcnt=0 next cycle.
- Hazard types: a load-use hit and an MDU hit in the same cycle give a single stall. FSM entry is still taken.
- Idle outputs: pc_write_o=1, ifid_write_o=1, all flushes 0.

## Timing
- Reset: while rst_i is high, pc_write_o=0, ifid_write_o=0, if/id/ex_flush_o=1, busy_o=0. Next edge gives state IDLE, lcnt=0, mdu_cnt=0. Reset mid-stall or mid-MDU aborts immediately.
- Detection-to-stall latency is 0 cycles (combinational). Total load bubbles are exactly LOAD_STALL.
- The MDU op issued in cycle N blocks dependent ops in cycles N+1 .. N+MDU_LAT.
- pc_src_i in the same cycle as a hazard: branch response only. pc_src_i during LSTALL exits next cycle.
- Only state, lcnt and mdu_cnt are registered. Outputs are combinational from state and inputs.

## Structure
- Package hazard_pkg holds the FSM state enum (IDLE, LSTALL), counter-width localparams ($clog2 of LOAD_STALL+1 and MDU_LAT+1), and parameter range checks.
- One sub-module, hazard_cnt: loadable saturating down-counter (load, value, dec, zero flag), instantiated for lcnt and mdu_cnt.

## Test plan
- LOAD_STALL=1: ex_memread_i=1, ex_rt_i=8, id_rs_i=8, id_uses_rs_i=1 -> one cycle of pc_write_o=0, ifid_write_o=0, id_flush_o=1, then normal.
- LOAD_STALL=3, same hit, held for 1 cycle -> exactly 3 stall cycles. ex_rt_i=0 with id_rs_i=0 -> no stall.
- MDU_LAT=4: mult issued in cycle 0, mfhi presented from cycle 1 -> stall cycles 1-4, mfhi passes in cycle 5.
- BR_FLUSH_DEPTH=2: pc_src_i=1 during LSTALL (LOAD_STALL=3, 2nd bubble) -> if/id_flush_o=1, ex_flush_o=0, pc_write_o=1, and the FSM is IDLE next cycle.
- rst_i asserted mid-LSTALL and mid-MDU -> outputs take reset values that cycle. After release, busy_o=0 and no residual stall.
